spi_master: RTL and testbench

Parametrised SPI master, successor to the transmit-only 8-bit SPI FSM. It adds full-duplex MISO capture, chip-select generation and runtime CPOL/CPHA modes, and generalises word width and SCLK divider. It sits between the measurement control logic and the external ADC/DAC SPI pins. It runs one word per `start` and returns the received word with a one-cycle `done` pulse.

---
 rtl/spi_master.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Parametrised full-duplex SPI master: one BITS-wide word per start, runtime CPOL/CPHA.
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first on mosi and miso.
module spi_master #(
  parameter int BITS = 8,
  parameter int HALF = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] tx_data,
  input  logic            cpol,
  input  logic            cpha,
  input  logic            miso,
  output logic            sclk,
  output logic            mosi,
  output logic            cs_n,
  output logic [BITS-1:0] rx_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(BITS) + 1;
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            trail_q, trail_d;
  logic [BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BITS-1:0] rx_shift_q, rx_shift_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic [BITS-1:0] rx_data_q, rx_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            half_end;
  logic [CW-1:0]   bit_cnt_inc;
  logic            tx_head;
  logic [BITS-1:0] tx_rest;
  logic            load_head;
  logic [BITS-1:0] load_rest;
  logic [BITS-1:0] rx_shifted;

  assign half_end    = (half_cnt_q == HALF_LAST);
  assign bit_cnt_inc = bit_cnt_q + CW'(1);

  // Bit order only changes which end of the shifters is used; timing is shared.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_head    = tx_shift_q[0];
  assign tx_rest    = {1'b0, tx_shift_q[BITS-1:1]};
  assign load_head  = tx_data[0];
  assign load_rest  = {1'b0, tx_data[BITS-1:1]};
  assign rx_shifted = {miso, rx_shift_q[BITS-1:1]};
`else
  assign tx_head    = tx_shift_q[BITS-1];
  assign tx_rest    = {tx_shift_q[BITS-2:0], 1'b0};
  assign load_head  = tx_data[BITS-1];
  assign load_rest  = {tx_data[BITS-2:0], 1'b0};
  assign rx_shifted = {rx_shift_q[BITS-2:0], miso};
`endif

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    trail_d    = trail_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = S_SETUP;
          cpol_d     = cpol;
          cpha_d     = cpha;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          trail_d    = 1'b0;
          rx_shift_d = '0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          // cpha=0 presents the first bit before the first edge; cpha=1 drives it on that edge.
          if (cpha) begin
            mosi_d     = 1'b0;
            tx_shift_d = tx_data;
          end else begin
            mosi_d     = load_head;
            tx_shift_d = load_rest;
          end
        end
      end

      S_SETUP: begin
        sclk_d     = cpol_q;
        half_cnt_d = half_cnt_q + HW'(1);
        if (half_end) begin
          half_cnt_d = '0;
          state_d    = S_XFER;
        end
      end

      S_XFER: begin
        half_cnt_d = half_cnt_q + HW'(1);
        if (half_end) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          trail_d    = ~trail_q;
          // Leading edges sample when cpha=0, trailing edges when cpha=1.
          if (trail_q == cpha_q) begin
            rx_shift_d = rx_shifted;
          end
          if (!trail_q) begin
            if (cpha_q) begin
              mosi_d     = tx_head;
              tx_shift_d = tx_rest;
            end
          end else begin
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == BIT_LAST) begin
              state_d = S_HOLD;
            end else if (!cpha_q) begin
              mosi_d     = tx_head;
              tx_shift_d = tx_rest;
            end
          end
        end
      end

      S_HOLD: begin
        sclk_d     = cpol_q;
        half_cnt_d = half_cnt_q + HW'(1);
        if (half_end) begin
          half_cnt_d = '0;
          state_d    = S_DONE;
          done_d     = 1'b1;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_shift_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sclk_d  = cpol;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      trail_q    <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      trail_q    <= trail_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed mode/start/reset cases plus random words,
// checked against a bit-order/timing model derived from the protocol rules.
module tb_spi_master;
  localparam int BITS  = 8;
  localparam int HALF  = 2;
  localparam int T_LE  = HALF * (2 * BITS + 1);
  localparam int T_DN  = HALF * (2 * BITS + 2);
  localparam int LIMIT = T_DN + 20;

  logic            clk = 1'b0;
  logic            rst, start, cpol, cpha, miso;
  logic [BITS-1:0] tx_data, rx_data;
  logic            sclk, mosi, cs_n, busy, done;

  always #5 clk = ~clk;

  spi_master #(.BITS(BITS), .HALF(HALF)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  // Bus monitor state (written only by the monitor process)
  int   cyc = 0, edge_cnt = 0, samp_cnt = 0, done_cnt = 0, last_edge_cyc = 0;
  logic sclk_prev = 1'b0;
  logic mosi_seen[$];

  // Stimulus-owned transfer context
  logic            mode_cpol = 1'b0, mode_cpha = 1'b0, loop_en = 1'b1;
  logic [BITS-1:0] slave_vec = '0;
  int              samp_base = 0;
  logic            slave_bit;
  logic [BITS-1:0] last_rx = '0;

  // Word bit index carried by the k-th bit on the wire
  function automatic int order(int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return k;
`else
    return BITS - 1 - k;
`endif
  endfunction

  always_comb begin
    slave_bit = 1'b0;
    for (int k = 0; k < BITS; k++)
      if (samp_cnt - samp_base == k) slave_bit = slave_vec[k];
  end
  assign miso = loop_en ? mosi : slave_bit;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= sclk;
    if (cs_n === 1'b0 && sclk !== sclk_prev) begin
      edge_cnt      <= edge_cnt + 1;
      last_edge_cyc <= cyc + 1;
      if ((sclk_prev == mode_cpol) ^ mode_cpha) begin
        mosi_seen.push_back(mosi);
        samp_cnt <= samp_cnt + 1;
      end
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS-1:0] mosi_word(int base);
    logic [BITS-1:0] w = '0;
    for (int k = 0; k < BITS; k++)
      if (base + k < mosi_seen.size()) w[order(k)] = mosi_seen[base + k];
    return w;
  endfunction

  task automatic set_mode(input logic pol, input logic pha, input logic lp,
                          input logic [BITS-1:0] tx, input logic [BITS-1:0] sw);
    mode_cpol = pol; mode_cpha = pha; cpol = pol; cpha = pha;
    loop_en = lp; tx_data = tx;
    for (int k = 0; k < BITS; k++) slave_vec[k] = sw[order(k)];
    samp_base = samp_cnt;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < LIMIT) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_xfer(input logic [BITS-1:0] tx, input logic pol, input logic pha,
                          input logic lp, input logic [BITS-1:0] sw, input int mid_k,
                          input string tag);
    int t1, eb, db, mb, k, done_k;
    logic [BITS-1:0] exp_rx;
    set_mode(pol, pha, lp, tx, sw);
    eb = edge_cnt; db = done_cnt; mb = mosi_seen.size();
    exp_rx = lp ? tx : sw;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_idle_sclk"}, 32'(sclk), 32'(pol));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t1 = cyc + 1;
    check({tag, "_cs_fall"}, 32'(cs_n), 32'd0);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_setup_sclk"}, 32'(sclk), 32'(pol));
    k = 0; done_k = -1;
    while (done_k < 0 && k < LIMIT) begin
      if (mid_k > 0 && k == mid_k) begin
        start = 1'b1; tx_data = '1; cpol = ~pol; cpha = ~pha;
      end
      if (mid_k > 0 && k == mid_k + 1) begin
        start = 1'b0; tx_data = tx; cpol = pol; cpha = pha;
      end
      @(posedge clk); #1; k++;
      if (k == HALF * BITS) check({tag, "_rx_hold"}, 32'(rx_data), 32'(last_rx));
      if (done === 1'b1) done_k = k;
    end
    check({tag, "_done_time"}, 32'(done_k), 32'(T_DN));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_done_cs"}, 32'(cs_n), 32'd1);
    check({tag, "_done_mosi"}, 32'(mosi), 32'd0);
    check({tag, "_end_sclk"}, 32'(sclk), 32'(pol));
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_edges"}, 32'(edge_cnt - eb), 32'(2 * BITS));
    check({tag, "_last_edge"}, 32'(last_edge_cyc - t1), 32'(T_LE));
    check({tag, "_done_count"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_mosi_bits"}, 32'(mosi_seen.size() - mb), 32'(BITS));
    check({tag, "_mosi_word"}, 32'(mosi_word(mb)), 32'(tx));
    last_rx = exp_rx;
  endtask

  initial begin
    int mb, db;
    logic [BITS-1:0] rtx, rsw;
    logic rpol, rpha, rlp;

    rst = 1'b1; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rx", 32'(rx_data), 32'd0);
    rst = 1'b0;

    run_xfer(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, -1, "mode0_loop");
    run_xfer(8'h81, 1'b1, 1'b1, 1'b0, 8'h3C, -1, "mode3_slave");
    run_xfer(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, HALF * 6, "mid_start");

    // start held high across two words
    set_mode(1'b0, 1'b0, 1'b1, 8'h5A, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    mb = mosi_seen.size();
    start = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hC3;
    wait_done("held_w1");
    check("held_w1_rx", 32'(rx_data), 32'h5A);
    @(posedge clk); #1;
    check("held_gap_cs_n", 32'(cs_n), 32'd1);
    check("held_gap_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_w2_cs_n", 32'(cs_n), 32'd0);
    check("held_w2_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("held_w2");
    check("held_w2_rx", 32'(rx_data), 32'hC3);
    check("held_mosi_w1", 32'(mosi_word(mb)), 32'h5A);
    check("held_mosi_w2", 32'(mosi_word(mb + BITS)), 32'hC3);
    last_rx = 8'hC3;
    repeat (2) @(posedge clk);

    // reset in the middle of bit 4, idle level high so sclk=0 is visible
    set_mode(1'b1, 1'b1, 1'b1, 8'h96, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < LIMIT && samp_cnt - samp_base < 4; k++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_reached", 32'(samp_cnt - samp_base), 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_mosi", 32'(mosi), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rx", 32'(rx_data), 32'd0);
    db = done_cnt;
    repeat (T_DN + 4) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - db), 32'd0);
    last_rx = '0;
    run_xfer(8'h3E, 1'b1, 1'b1, 1'b1, 8'h00, -1, "after_rst");

    // single set bit at position 0 exposes the shift order on the first wire bit
    mb = mosi_seen.size();
    run_xfer(8'h01, 1'b0, 1'b0, 1'b1, 8'h00, -1, "order01");
    check("order01_first_bit", 32'(mosi_seen[mb]), (order(0) == 0) ? 32'd1 : 32'd0);

    for (int n = 0; n < 8; n++) begin
      rtx  = BITS'($urandom);
      rsw  = BITS'($urandom);
      rpol = 1'($urandom);
      rpha = 1'($urandom);
      rlp  = 1'($urandom);
      run_xfer(rtx, rpol, rpha, rlp, rsw, -1, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
